if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  (system clock, all state on rising edge).
REQ-003 SHALL have port rst  in  1  (asynchronous, active-low reset).
REQ-004 SHALL have port inst_req  out  1  (fetch request to instruction bus).
REQ-005 SHALL have port inst_addr  out  64  (fetch address, valid while inst_req=1).
REQ-006 SHALL have port inst_ready  in  1  (bus accepts the request this cycle).
REQ-007 SHALL have port inst_rvalid  in  1  (returned instruction word valid).
REQ-008 SHALL have port inst_rdata  in  32  (returned instruction word).
REQ-009 SHALL have port redirect  in  1  (branch/jump taken, from execute).
REQ-010 SHALL have port redirect_pc  in  64  (redirect target).
REQ-011 SHALL have port id_ready  in  1  (decode consumes inst_out this cycle).
REQ-012 SHALL have port inst_valid  out  1  (inst_out/pc_out valid to decode).
REQ-013 SHALL have port inst_out  out  32  (instruction to decode).
REQ-014 SHALL have port pc_out  out  64  (PC of inst_out).

Function
REQ-015 SHALL implement FSM states REQ, WAIT, HOLD, DROP, with exactly one outstanding bus request.
REQ-016 REQ: inst_req=1, inst_addr=pc; inst_ready -> WAIT.
REQ-017 WAIT: inst_req=0; inst_rvalid -> capture inst_rdata into inst buffer, -> HOLD.
REQ-018 HOLD: inst_valid=1, inst_out=buffer, pc_out=pc; id_ready -> pc<=pc+4, -> REQ.
REQ-019 DROP: inst_req=0, inst_valid=0; inst_rvalid -> discard data, -> REQ.
REQ-020 inst_valid SHALL be 1 only in HOLD; latency inst_rvalid -> inst_valid is exactly 1 cycle.
REQ-021 redirect SHALL have priority over all other events; pc<=redirect_pc with bits [1:0] forced to 0.
REQ-022 redirect in REQ: inst_ready=0 -> stay REQ; inst_ready=1 -> DROP (accepted request is stale).
REQ-023 redirect in WAIT: inst_rvalid=1 same cycle -> discard data, REQ; else -> DROP.
REQ-024 redirect in HOLD: buffer discarded regardless of id_ready, pc not incremented, -> REQ; inst_valid=0 next cycle.
REQ-025 redirect in DROP: pc updated, remain DROP until inst_rvalid.
REQ-026 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-027 inst_ready/inst_rvalid outside REQ/WAIT respectively (except DROP) SHALL be ignored.

Reset
REQ-028 rst=0 SHALL immediately force pc=RESET_PC, state REQ, buffer=0, inst_valid=0, inst_out=0, pc_out=0, inst_req=0.
REQ-029 First inst_req=1 SHALL appear in the first cycle after rst deasserts.
REQ-030 Reset mid-request SHALL abandon the request; any stray inst_rvalid arriving after reset release while in REQ SHALL be ignored.

Configuration
REQ-031 Macro IF_PERF_CNT_EN defined: SHALL add outputs perf_fetch (64, count of HOLD->REQ handoffs via id_ready) and perf_bubble (64, cycles with inst_valid=0), both reset to 0, wrapping.
REQ-032 Macro undefined: these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-033 FSM state encoding, RESET_PC default and instruction-width constants SHALL live in the shared defines package.
REQ-034 Counters SHALL be a sub-module if_perf_cnt, instantiated only under IF_PERF_CNT_EN; FSM and PC stay in if_stage.

Verification
REQ-035 Reset release, inst_ready=1 immediately, rvalid 2 cycles later with 32'h00000013, id_ready=1 -> inst_addr=0x80000000, inst_valid one cycle after rvalid, next inst_addr=0x80000004.
REQ-036 id_ready=0 for 5 cycles in HOLD -> inst_valid, inst_out, pc_out stable, inst_req=0 throughout.
REQ-037 redirect to 0x80001002 while WAIT, rvalid 3 cycles later -> data discarded, inst_valid never 1 for it, next inst_addr=0x80001000.
REQ-038 redirect coincident with inst_ready in REQ -> DROP; next fetch issued only after stale rvalid.
REQ-039 pc=0xFFFFFFFFFFFFFFFC consumed -> next inst_addr=0.
REQ-040 With IF_PERF_CNT_EN: 3 instructions delivered over 10 cycles after reset -> perf_fetch=3, perf_bubble=7.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: widths, reset PC,
// fetch FSM state encoding and PC alignment helper.
package if_stage_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 64'd4;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// Free-running 64-bit event counters for the fetch stage (fetch handoffs and
// bubble cycles). Only instantiated when IF_PERF_CNT_EN is defined.
module if_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        bubble_inc,
    output logic [63:0] perf_fetch,
    output logic [63:0] perf_bubble
);

    logic [1:0]       inc;
    logic [1:0][63:0] cnt_all;

    assign inc = {bubble_inc, fetch_inc};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [63:0] cnt_q;
        logic [63:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (inc[gi]) begin
                cnt_d = cnt_q + 64'd1;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_all[gi] = cnt_q;
    end

    assign perf_fetch  = cnt_all[0];
    assign perf_bubble = cnt_all[1];

endmodule

// File: rtl/if_stage.sv
// Single-outstanding-request instruction fetch stage with redirect support.
// Optional performance counters are enabled with the IF_PERF_CNT_EN macro.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            inst_req,
    output logic [XLEN-1:0] inst_addr,
    input  logic            inst_ready,
    input  logic            inst_rvalid,
    input  logic [ILEN-1:0] inst_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            inst_valid,
    output logic [ILEN-1:0] inst_out,
    output logic [XLEN-1:0] pc_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [63:0]     perf_fetch,
    output logic [63:0]     perf_bubble
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] buf_q, buf_d;
    logic            hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;

        // Redirect always retargets the PC; the state transition below decides
        // whether an in-flight response must still be swallowed.
        if (redirect) begin
            pc_d = align_pc(redirect_pc);
        end

        unique case (state_q)
            ST_REQ: begin
                if (inst_ready) begin
                    state_d = redirect ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    state_d = inst_rvalid ? ST_REQ : ST_DROP;
                end else if (inst_rvalid) begin
                    buf_d   = inst_rdata;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    state_d = ST_REQ;
                end else if (id_ready) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (inst_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    assign hold = (state_q == ST_HOLD);

    // While reset is asserted the state already reads REQ, so the request is
    // gated with rst to keep the bus quiet until release.
    assign inst_req   = rst && (state_q == ST_REQ);
    assign inst_addr  = pc_q;
    assign inst_valid = hold;
    assign inst_out   = hold ? buf_q : '0;
    assign pc_out     = hold ? pc_q : '0;

`ifdef IF_PERF_CNT_EN
    if_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .fetch_inc   (hold && id_ready && !redirect),
        .bubble_inc  (!hold),
        .perf_fetch  (perf_fetch),
        .perf_bubble (perf_bubble)
    );
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized and directed self-checking bench for if_stage, compared against a
// transaction-level model of the fetch stage kept in the bench.
module tb_if_stage;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [63:0] inst_addr;
    logic        inst_ready;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        id_ready;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [63:0] pc_out;
`ifdef IF_PERF_CNT_EN
    logic [63:0] perf_fetch;
    logic [63:0] perf_bubble;
`endif

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_ready  (inst_ready),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .inst_valid  (inst_valid),
        .inst_out    (inst_out),
        .pc_out      (pc_out)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_bubble (perf_bubble)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit verbose  = 1'b1;

    // Model: a fetch is outstanding or an instruction is held, never both;
    // a request is issued whenever neither is true.
    logic [63:0] m_pc;
    bit          m_out;
    bit          m_stale;
    bit          m_have;
    logic [31:0] m_buf;
    logic [63:0] m_fetch;
    logic [63:0] m_bubble;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_out    = 1'b0;
        m_stale  = 1'b0;
        m_have   = 1'b0;
        m_buf    = '0;
        m_fetch  = '0;
        m_bubble = '0;
    endtask

    task automatic check_outputs();
        bit issuing;
        issuing = !m_out && !m_have;
        check("inst_req", {63'd0, inst_req}, {63'd0, issuing});
        if (issuing) check("inst_addr", inst_addr, m_pc);
        check("inst_valid", {63'd0, inst_valid}, {63'd0, m_have});
        check("inst_out", {32'd0, inst_out}, m_have ? {32'd0, m_buf} : 64'd0);
        check("pc_out", pc_out, m_have ? m_pc : 64'd0);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch", perf_fetch, m_fetch);
        check("perf_bubble", perf_bubble, m_bubble);
`endif
    endtask

    // Entered and left just after a falling edge: drive, check, clock, update model.
    task automatic step(input bit rdy, input bit rv, input logic [31:0] rd,
                        input bit redir, input logic [63:0] rpc, input bit idr);
        bit issuing;
        inst_ready  = rdy;
        inst_rvalid = rv;
        inst_rdata  = rd;
        redirect    = redir;
        redirect_pc = rpc;
        id_ready    = idr;
        #1;
        check_outputs();
        @(posedge clk);
        if (!m_have) m_bubble++;
        if (m_have && idr && !redir) begin
            m_fetch++;
            if (verbose) $display("deliver pc=%h inst=%h", m_pc, m_buf);
        end
        issuing = !m_out && !m_have;
        if (issuing) begin
            if (rdy) begin
                m_out   = 1'b1;
                m_stale = redir;
            end
        end else if (m_out) begin
            if (rv) begin
                m_out = 1'b0;
                if (!m_stale && !redir) begin
                    m_have = 1'b1;
                    m_buf  = rd;
                end
            end
        end else if (redir || idr) begin
            m_have = 1'b0;
            if (!redir) m_pc = m_pc + 64'd4;
        end
        if (redir) begin
            m_pc = {rpc[63:2], 2'b00};
            if (m_out) m_stale = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 64'h0, 0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
    task automatic apply_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("rst_inst_req", {63'd0, inst_req}, 64'd0);
        check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("rst_inst_out", {32'd0, inst_out}, 64'd0);
        check("rst_pc_out", pc_out, 64'd0);
        check("rst_pc", inst_addr, RESET_PC);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst         = 1'b0;
        inst_ready  = 1'b0;
        inst_rvalid = 1'b0;
        inst_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Basic fetch: accept, response two cycles later, consumed at once.
        $display("scenario: basic fetch");
        check("first_addr", inst_addr, 64'h8000_0000);
        step(1, 0, 32'h0, 0, 64'h0, 0);
        step(0, 0, 32'h0, 0, 64'h0, 0);
        step(0, 1, 32'h0000_0013, 0, 64'h0, 0);
        check("first_inst", {32'd0, inst_out}, 64'h13);
        step(0, 0, 32'h0, 0, 64'h0, 1);
        check("second_addr", inst_addr, 64'h8000_0004);

        // Decode stalls for five cycles while the instruction is held.
        $display("scenario: decode stall");
        step(1, 0, 32'h0, 0, 64'h0, 0);
        step(0, 1, 32'hDEAD_BEEF, 0, 64'h0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 32'h1234_5678, 0, 64'h0, 0);
        step(0, 0, 32'h0, 0, 64'h0, 1);

        // Redirect while waiting; late response must be dropped.
        $display("scenario: redirect in wait");
        step(1, 0, 32'h0, 0, 64'h0, 0);
        step(0, 0, 32'h0, 1, 64'h8000_1002, 0);
        step(0, 0, 32'h0, 0, 64'h0, 1);
        step(1, 0, 32'h0, 0, 64'h0, 1);
        step(0, 1, 32'hBAD0_BAD0, 0, 64'h0, 1);
        check("redir_valid", {63'd0, inst_valid}, 64'd0);
        check("redir_addr", inst_addr, 64'h8000_1000);

        // Redirect coincident with acceptance: stale response swallowed first.
        $display("scenario: redirect on accept");
        step(1, 0, 32'h0, 1, 64'h0000_4000, 0);
        step(1, 0, 32'h0, 0, 64'h0, 0);
        check("drop_no_req", {63'd0, inst_req}, 64'd0);
        step(0, 1, 32'hBAD1_BAD1, 0, 64'h0, 1);
        check("drop_addr", inst_addr, 64'h0000_4000);

        // PC wrap at the top of the address space.
        $display("scenario: pc wrap");
        step(0, 0, 32'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        step(1, 0, 32'h0, 0, 64'h0, 0);
        step(0, 1, 32'h0000_0093, 0, 64'h0, 0);
        check("wrap_pc_out", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 32'h0, 0, 64'h0, 1);
        check("wrap_addr", inst_addr, 64'h0);

`ifdef IF_PERF_CNT_EN
        // Three instructions in ten cycles after reset.
        $display("scenario: perf counters");
        @(negedge clk);
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 32'h0, 0, 64'h0, 0);
            step(0, 1, 32'h13, 0, 64'h0, 0);
            step(0, 0, 32'h0, 0, 64'h0, 1);
        end
        step(0, 0, 32'h0, 0, 64'h0, 0);
        #1;
        check("perf_fetch_10", perf_fetch, 64'd3);
        check("perf_bubble_10", perf_bubble, 64'd7);
        @(negedge clk);
`endif

        // Randomized traffic with occasional resets and redirects.
        $display("scenario: random traffic");
        verbose = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            logic [63:0] rpc;
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFFD;
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
                step(0, 1, $urandom, 0, 64'h0, $urandom_range(0, 1));
            end else begin
                step($urandom_range(0, 1), $urandom_range(0, 9) < 4, $urandom,
                     $urandom_range(0, 11) == 0, rpc, $urandom_range(0, 1));
            end
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
